// File: rtl/rstseq_ctl_pkg.sv
// Shared definitions for the reset-release sequencer: FSM state encoding
// and the default delay constants.
package rstseq_ctl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_SCAN   = 3'd1,
        ST_GAP    = 3'd2,
        ST_DONE   = 3'd3,
        ST_SWHOLD = 3'd4,
        ST_SWREL  = 3'd5
    } state_t;

    localparam int NDOM_DEF      = 22;
    localparam int PWRUP_DLY_DEF = 16;
    localparam int STEP_DLY_DEF  = 4;
    localparam int HOLD_DLY_DEF  = 8;
    localparam int CW_DEF        = 8;
    localparam int IDXW          = 5;

endpackage

// File: rtl/rstseq_tmr.sv
// Shared delay timer: up-counter with clear/enable; expired is high while
// the count equals the limit (limit = delay-1).
module rstseq_tmr #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] lim,
    output logic          expired
);

    logic [CW-1:0] cnt_q;

    // Count while enabled; clear has priority so every state entry starts at 0.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == lim);

endmodule

// File: rtl/rstseq_ctl.sv
// Reset-release sequencer: holds all domains after power-up, releases the
// enabled ones in index order with a gap, then services software resets.
//
//  state  | meaning
//  PWRUP  | power-up hold, counting PWRUP_DLY edges
//  SCAN   | one edge per index; release domain if enabled
//  GAP    | STEP_DLY spacing edges after a release
//  DONE   | sequence complete; waiting for pending software resets
//  SWHOLD | captured group held for HOLD_DLY edges
//  SWREL  | group just released, ack pulse visible this cycle
module rstseq_ctl
    import rstseq_ctl_pkg::*;
#(
    parameter int NDOM      = NDOM_DEF,
    parameter int PWRUP_DLY = PWRUP_DLY_DEF,
    parameter int STEP_DLY  = STEP_DLY_DEF,
    parameter int HOLD_DLY  = HOLD_DLY_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            scanmode,
    input  logic [NDOM-1:0] cfg_en,
    input  logic            seq_restart,
    input  logic [NDOM-1:0] swrst_req,
    output logic [NDOM-1:0] swrst_ack,
    output logic [NDOM-1:0] rstmsk,
    output logic            seq_busy,
    output logic            seq_done,
    output logic [4:0]      cur_dom
);

    localparam logic [CW-1:0]   PWRUP_LIM = CW'(PWRUP_DLY - 1);
    localparam logic [CW-1:0]   STEP_LIM  = CW'(STEP_DLY - 1);
    localparam logic [CW-1:0]   HOLD_LIM  = CW'(HOLD_DLY - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDOM - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NDOM-1:0]   pend_q, pend_d;
    logic [NDOM-1:0]   grp_q, grp_d;
    logic [NDOM-1:0]   rstmsk_q, rstmsk_d;
    logic [NDOM-1:0]   ack_q, ack_d;
    logic              tmr_clr, tmr_en, tmr_exp;
    logic [CW-1:0]     tmr_lim;

    rstseq_tmr #(.CW(CW)) u_tmr (
        .clk     (clk),
        .rst_    (rst_),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .lim     (tmr_lim),
        .expired (tmr_exp)
    );

    // State and datapath registers; reset holds every domain.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_PWRUP;
            idx_q    <= '0;
            pend_q   <= '0;
            grp_q    <= '0;
            rstmsk_q <= '1;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            grp_q    <= grp_d;
            rstmsk_q <= rstmsk_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state and datapath updates; restart overrides everything.
    // The timer is cleared on any cycle that is not actively counting.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q | (swrst_req & cfg_en);
        grp_d    = grp_q;
        rstmsk_d = rstmsk_q;
        ack_d    = '0;
        tmr_clr  = 1'b1;
        tmr_en   = 1'b0;
        tmr_lim  = '0;

        if (seq_restart) begin
            state_d  = ST_PWRUP;
            idx_d    = '0;
            pend_d   = '0;
            grp_d    = '0;
            rstmsk_d = '1;
        end else begin
            case (state_q)
                ST_PWRUP: begin
                    tmr_lim = PWRUP_LIM;
                    if (tmr_exp) begin
                        state_d = ST_SCAN;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_en  = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cfg_en[idx_q]) begin
                        rstmsk_d[idx_q] = 1'b0;
                        state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_GAP;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                ST_GAP: begin
                    tmr_lim = STEP_LIM;
                    if (tmr_exp) begin
                        state_d = ST_SCAN;
                        idx_d   = idx_q + IDXW'(1);
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_en  = 1'b1;
                    end
                end
                ST_DONE: begin
                    // Captured bits clear; a request landing this cycle stays pending.
                    if (pend_q != '0) begin
                        grp_d    = pend_q;
                        pend_d   = swrst_req & cfg_en;
                        rstmsk_d = rstmsk_q | pend_q;
                        state_d  = ST_SWHOLD;
                    end
                end
                ST_SWHOLD: begin
                    tmr_lim = HOLD_LIM;
                    if (tmr_exp) begin
                        rstmsk_d = rstmsk_q & ~grp_q;
                        ack_d    = grp_q;
                        state_d  = ST_SWREL;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_en  = 1'b1;
                    end
                end
                ST_SWREL: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_PWRUP;
                end
            endcase
        end
    end

    assign rstmsk    = rstmsk_q & ~{NDOM{scanmode}};
    assign swrst_ack = ack_q;
    assign seq_busy  = (state_q != ST_DONE);
    assign seq_done  = (state_q == ST_DONE);
    assign cur_dom   = idx_q;

endmodule

// File: tb/tb_rstseq_ctl.sv
// Self-checking bench for rstseq_ctl: expected mask/ack/done snapshots are
// queued with the edge number they belong to and compared at the falling edge.
module tb_rstseq_ctl;

    localparam int ND    = 22;
    localparam int PWRUP = 16;
    localparam int STEP  = 4;
    localparam int BIG   = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_;
    logic          scanmode;
    logic [ND-1:0] cfg_en;
    logic          seq_restart;
    logic [ND-1:0] swrst_req;
    logic [ND-1:0] swrst_ack;
    logic [ND-1:0] rstmsk;
    logic          seq_busy;
    logic          seq_done;
    logic [4:0]    cur_dom;

    rstseq_ctl dut (
        .clk         (clk),
        .rst_        (rst_),
        .scanmode    (scanmode),
        .cfg_en      (cfg_en),
        .seq_restart (seq_restart),
        .swrst_req   (swrst_req),
        .swrst_ack   (swrst_ack),
        .rstmsk      (rstmsk),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .cur_dom     (cur_dom)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release (edge 1 = first rising edge).
    int cyc;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int            t;
        logic [ND-1:0] msk;
        logic [ND-1:0] ack;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rel[ND];
    int   done_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input int t, input logic [ND-1:0] m, input logic [ND-1:0] a, input logic d);
        exp_t e;
        e.t = t; e.msk = m; e.ack = a; e.done = d;
        sb.push_back(e);
    endtask

    function automatic logic [ND-1:0] msk_at(input int t);
        logic [ND-1:0] m;
        m = '1;
        for (int k = 0; k < ND; k++)
            if (rel[k] >= 0 && rel[k] <= t) m[k] = 1'b0;
        return m;
    endfunction

    // Release-edge model of the power-up sequence starting from edge 'base'.
    task automatic plan_scan(input int base, input logic [ND-1:0] cfg, input int lim);
        int e;
        e = base + PWRUP + 1;
        for (int k = 0; k < ND; k++) begin
            if (cfg[k]) begin
                rel[k] = e;
                if (k < ND-1) e += STEP + 1;
            end else begin
                rel[k] = -1;
                if (k < ND-1) e += 1;
            end
        end
        done_e = e;
        if (base + PWRUP <= lim) push(base + PWRUP, '1, '0, 1'b0);
        for (int k = 0; k < ND; k++) begin
            if (rel[k] >= 0) begin
                if (rel[k] - 1 <= lim) push(rel[k] - 1, msk_at(rel[k] - 1), '0, 1'b0);
                if (rel[k] <= lim)     push(rel[k], msk_at(rel[k]), '0, rel[k] >= done_e);
            end
        end
        if (done_e <= lim) push(done_e, msk_at(done_e), '0, 1'b1);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            e = sb.pop_front();
            if (e.t < cyc) begin
                check($sformatf("sb_late@%0d", e.t), cyc, e.t);
            end else begin
                check($sformatf("msk@%0d", e.t), rstmsk, e.msk);
                check($sformatf("ack@%0d", e.t), swrst_ack, e.ack);
                check($sformatf("done@%0d", e.t), seq_done, e.done);
            end
        end
    endtask

    task automatic tick_to(input int n);
        for (int i = 0; i < 5000 && cyc < n; i++) tick();
        check("tick_to", cyc, n);
    endtask

    int c, r1, r2, r3;

    initial begin
        rst_ = 1'b0; scanmode = 1'b0; cfg_en = '1; seq_restart = 1'b0; swrst_req = '0;

        // reset values
        #12;
        check("rst_msk", rstmsk, {ND{1'b1}});
        check("rst_ack", swrst_ack, 0);
        check("rst_busy", seq_busy, 1);
        check("rst_done", seq_done, 0);
        check("rst_dom", cur_dom, 0);
        @(negedge clk);
        rst_ = 1'b1;

        // full sequence, all enabled, with a scanmode blip during power-up
        plan_scan(0, '1, BIG);
        tick_to(5);
        scanmode = 1'b1;
        #1 check("scan_msk", rstmsk, 0);
        check("scan_busy", seq_busy, 1);
        scanmode = 1'b0;
        #1 check("scan_restore", rstmsk, {ND{1'b1}});
        tick_to(140);
        check("done_dom", cur_dom, ND-1);

        // software reset group, second request arrives during hold
        c = cyc;
        push(c+2,  22'h000030, '0, 1'b0);
        push(c+9,  22'h000030, '0, 1'b0);
        push(c+10, '0, 22'h000030, 1'b0);
        push(c+11, '0, '0, 1'b1);
        push(c+12, 22'h000200, '0, 1'b0);
        push(c+19, 22'h000200, '0, 1'b0);
        push(c+20, '0, 22'h000200, 1'b0);
        push(c+21, '0, '0, 1'b1);
        swrst_req = 22'h000030;
        tick();
        swrst_req = '0;
        tick_to(c+4);
        swrst_req = 22'h000200;
        tick();
        swrst_req = '0;
        tick_to(c+25);

        // restart from DONE, then restart again in GAP at index 7
        r1 = cyc + 1;
        push(r1, '1, '0, 1'b0);
        plan_scan(r1, '1, r1 + 53);
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        check("rs1_dom", cur_dom, 0);
        check("rs1_busy", seq_busy, 1);
        tick_to(r1 + 53);
        check("gap_idx", cur_dom, 7);
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        r2 = r1 + 54;
        check("rs2_msk", rstmsk, {ND{1'b1}});
        check("rs2_dom", cur_dom, 0);
        plan_scan(r2, '1, BIG);
        push(r2+123, 22'h000008, '0, 1'b0);
        push(r2+130, 22'h000008, '0, 1'b0);
        push(r2+131, '0, 22'h000008, 1'b0);
        push(r2+132, '0, '0, 1'b1);
        tick_to(r2 + 29);
        swrst_req = 22'h000008;
        tick();
        swrst_req = '0;
        tick_to(r2 + 140);

        // bits 0 and 2 disabled; request on a disabled bit is dropped
        cfg_en = 22'h3FFFFA;
        r3 = cyc + 1;
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        plan_scan(r3, 22'h3FFFFA, BIG);
        tick_to(done_e + 2);
        c = cyc;
        push(c+2,  22'h000007, '0, 1'b0);
        push(c+10, 22'h000005, 22'h000002, 1'b0);
        push(c+11, 22'h000005, '0, 1'b1);
        push(c+15, 22'h000005, '0, 1'b1);
        swrst_req = 22'h000003;
        tick();
        swrst_req = '0;
        tick_to(c + 16);

        // async reset in the middle of a software hold
        c = cyc;
        push(c+2, 22'h000015, '0, 1'b0);
        swrst_req = 22'h000010;
        tick();
        swrst_req = '0;
        tick_to(c + 5);
        #2 rst_ = 1'b0;
        #1;
        check("arst_msk", rstmsk, {ND{1'b1}});
        check("arst_ack", swrst_ack, 0);
        check("arst_busy", seq_busy, 1);
        check("arst_done", seq_done, 0);
        check("arst_dom", cur_dom, 0);
        @(negedge clk);
        rst_ = 1'b1;
        plan_scan(0, 22'h3FFFFA, BIG);
        push(done_e + 12, 22'h000005, '0, 1'b1);
        tick_to(done_e + 14);

        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
